// File: rtl/tick_uart_pkg.sv
// Shared types and line levels for the tick-driven UART transmitter.
// Define TICK_UART_TX_PARITY_EN to add the even-parity state.
package tick_uart_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

`ifdef TICK_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

endpackage

// File: rtl/tick_uart_tx_if.sv
// Write-side valid/ready handshake into the transmitter FIFO.
// The master drives words; the slave (transmitter) returns in_ready.
interface tick_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/tick_uart_fifo.sv
// Purpose: small synchronous FIFO buffering words ahead of the serializer.
// Latency: a written word is readable (empty=0) the cycle after the write edge.
// Backpressure: full blocks writes, empty blocks reads; both flags registered-count based.
module tick_uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign do_wr  = wr_en && !full;
    assign do_rd  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/tick_uart_tx.sv
// Purpose: FIFO-fed UART serializer, LSB first, one line bit per tick (parity via TICK_UART_TX_PARITY_EN).
// Latency: start bit goes out on the first tick after a word becomes visible in the FIFO.
// Backpressure: in_ready = !fifo_full; words are held, never dropped or overwritten.
module tick_uart_tx
    import tick_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    tick_uart_tx_if.slave in_if,
    output logic          txd,
    output logic          busy,
    output logic          frame_done
);
    localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dat;
    logic              frame_end;
    logic              pop;
`ifdef TICK_UART_TX_PARITY_EN
    logic              par_bit;
`endif

    assign frame_end      = (state == STOP) && (stop_cnt == LAST_STOP);
    // Pop only on the tick that starts a frame, so the FIFO head is the next word to send.
    assign pop            = tick && !fifo_empty && ((state == IDLE) || frame_end);
    assign in_if.in_ready = !fifo_full;

    tick_uart_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_if.in_valid),
        .wr_dat (in_if.in_data),
        .rd_en  (pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            txd        <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
`ifdef TICK_UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            shreg   <= fifo_dat;
                            txd     <= START_LEVEL;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= START;
`ifdef TICK_UART_TX_PARITY_EN
                            par_bit <= ^fifo_dat;
`endif
                        end
                    end
                    START: begin
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt != LAST_BIT) begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
`ifdef TICK_UART_TX_PARITY_EN
                            txd   <= par_bit;
                            state <= PARITY;
`else
                            txd      <= IDLE_LEVEL;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
`endif
                        end
                    end
`ifdef TICK_UART_TX_PARITY_EN
                    PARITY: begin
                        txd      <= IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
`endif
                    STOP: begin
                        if (stop_cnt != LAST_STOP) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            // Chain straight into the next start bit to avoid an idle gap.
                            if (!fifo_empty) begin
                                shreg   <= fifo_dat;
                                txd     <= START_LEVEL;
                                bit_cnt <= '0;
                                state   <= START;
`ifdef TICK_UART_TX_PARITY_EN
                                par_bit <= ^fifo_dat;
`endif
                            end else begin
                                txd   <= IDLE_LEVEL;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        txd   <= IDLE_LEVEL;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tick_uart_tx.md
TICK_UART_TX -- requirements
Module: tick_uart_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4, words buffered ahead of the serializer; power of two, at least 2.
REQ-003 Parameter STOP_BITS, default 1, stop-bit periods per frame; legal values 1 or 2.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 Port tick, input, 1, one-clk-wide bit-period strobe from the upstream clock divider (its tick output).
REQ-007 Port in_data, input, DATA_W, word to transmit.
REQ-008 Port in_valid, input, 1, in_data is valid.
REQ-009 Port in_ready, output, 1, FIFO can accept a word.
REQ-010 Port txd, output, 1, serial line; idle high; LSB first.
REQ-011 Port busy, output, 1, a frame is in progress.
REQ-012 Port frame_done, output, 1, one-clk pulse at the end of the last stop bit.

Function
REQ-013 A word shall be written on a clk edge with in_valid=1 and in_ready=1; in_ready shall equal !fifo_full (combinational).
REQ-014 in_data shall be ignored while in_ready=0; no overwrite or drop of stored words.
REQ-015 Serializer states: IDLE, START, DATA, PARITY, STOP; transitions only on clk edges with tick=1.
REQ-016 IDLE, tick=1, FIFO non-empty: pop the head word into the shift register, txd<=0, bit_cnt<=0, go to START. A word written on the same edge as a tick is not visible until the next tick.
REQ-017 START, tick: txd<=bit0, go to DATA.
REQ-018 DATA, tick: if bit_cnt<DATA_W-1, shift, txd<=next bit, bit_cnt+1; else go to PARITY (txd<=even parity of the word) or, without parity, go to STOP (txd<=1).
REQ-019 PARITY, tick: txd<=1, go to STOP, stop_cnt<=0.
REQ-020 STOP, tick: if stop_cnt<STOP_BITS-1, increment; else pulse frame_done, then either pop the next word (txd<=0, go to START) if the FIFO is non-empty, or go to IDLE with txd=1.
REQ-021 Each line bit shall last exactly one tick period; back-to-back frames have no idle gap.
REQ-022 busy=1 in every state except IDLE.
REQ-023 A push and pop on the same edge shall leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Tick pulses in IDLE with the FIFO empty shall have no effect.

Reset
REQ-025 rst=0 shall immediately force txd=1, busy=0, frame_done=0, state=IDLE, and empty the FIFO (in_ready=1). Mid-frame reset aborts the frame and discards stored words.
REQ-026 Ticks and writes during reset shall be ignored; operation resumes on the first tick after release.

Configuration
REQ-027 Macro TICK_UART_TX_PARITY_EN defined: the PARITY state exists and an even-parity bit follows the data bits.
REQ-028 Macro TICK_UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP.

Structure
REQ-029 Package tick_uart_pkg shall hold the state enum typedef and the constants IDLE_LEVEL=1 and START_LEVEL=0.
REQ-030 The FIFO shall be sub-module tick_uart_fifo (sync write/read, full/empty flags, async active-low reset).

Verification
REQ-031 Tick every 4 clks, push 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 (parity 0 if enabled, before the final 1), each bit 4 clks; frame_done pulses once.
REQ-032 Push 0x00 then 0xFF back-to-back -> second start bit immediately follows the first stop bit; busy stays high throughout.
REQ-033 With the serializer stalled (tick=0), push 5 words into FIFO_DEPTH=4 -> in_ready=0 after the 4th push; the 5th is held off until the first pop.
REQ-034 Assert rst=0 mid-DATA of 0x3C -> txd=1 and busy=0 in the same cycle; after release with no pushes, txd stays 1 through 10 ticks.
REQ-035 STOP_BITS=2 with parity enabled, push 0x07 -> 12 bit periods; parity bit=1; frame_done at the end of the 2nd stop bit.
REQ-036 A push on the same edge as a tick in IDLE -> start bit appears at the following tick, not the current one.
